// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC, small in-order instruction queue
// with redirect flush. Outputs present the queue head from registered state.
module fetch_unit #(
    parameter int N     = 32,
    parameter int PCW   = 64,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    output logic [5:0]     imem_addr,
    input  logic [N-1:0]   imem_q,
    input  logic           redirect,
    input  logic [PCW-1:0] redirect_pc,
    output logic           instr_valid,
    input  logic           instr_ready,
    output logic [N-1:0]   instr,
    output logic [PCW-1:0] instr_pc,
    output logic [3:0]     occupancy
);

    localparam int         PTRW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [PCW-1:0]  pc_r;
    logic [PTRW-1:0] head_r;
    logic [PTRW-1:0] tail_r;
    logic [3:0]      count_r;
    logic [N-1:0]    instr_mem_r [DEPTH];
    logic [PCW-1:0]  pc_mem_r    [DEPTH];
    logic [N-1:0]    instr_r;
    logic [PCW-1:0]  instr_pc_r;

    logic            pop_s;
    logic            push_s;
    logic [PCW-1:0]  pc_next_s;
    logic [PTRW-1:0] head_next_s;
    logic [PTRW-1:0] tail_next_s;
    logic [3:0]      count_next_s;
    logic [N-1:0]    instr_next_s;
    logic [PCW-1:0]  instr_pc_next_s;

    // Pointers wrap modulo DEPTH so non-power-of-two depths stay in order.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (p == PTRW'(DEPTH - 1)) begin
            return {PTRW{1'b0}};
        end else begin
            return p + PTRW'(1);
        end
    endfunction

    assign pop_s  = instr_valid && instr_ready;
    assign push_s = !redirect && ((count_r < DEPTH_C) || pop_s);

    // Next-state for pc, pointers and count; redirect overrides push and pop.
    always_comb begin
        pc_next_s    = pc_r;
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        count_next_s = count_r;
        if (redirect) begin
            pc_next_s    = redirect_pc & ~{{(PCW-2){1'b0}}, 2'b11};
            head_next_s  = {PTRW{1'b0}};
            tail_next_s  = {PTRW{1'b0}};
            count_next_s = 4'd0;
        end else begin
            head_next_s  = pop_s  ? ptr_inc(head_r) : head_r;
            tail_next_s  = push_s ? ptr_inc(tail_r) : tail_r;
            count_next_s = count_r + {3'b000, push_s} - {3'b000, pop_s};
            pc_next_s    = push_s ? (pc_r + PCW'(4)) : pc_r;
        end
    end

    // Head entry after this edge; a word pushed into the new head slot bypasses the array.
    always_comb begin
        instr_next_s    = instr_r;
        instr_pc_next_s = instr_pc_r;
        if (count_next_s != 4'd0) begin
            if (push_s && (tail_r == head_next_s)) begin
                instr_next_s    = imem_q;
                instr_pc_next_s = pc_r;
            end else begin
                instr_next_s    = instr_mem_r[head_next_s];
                instr_pc_next_s = pc_mem_r[head_next_s];
            end
        end else begin
            instr_next_s    = instr_r;
            instr_pc_next_s = instr_pc_r;
        end
    end

    // State registers; outputs hold their last value while the queue is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r       <= {PCW{1'b0}};
            head_r     <= {PTRW{1'b0}};
            tail_r     <= {PTRW{1'b0}};
            count_r    <= 4'd0;
            instr_r    <= {N{1'b0}};
            instr_pc_r <= {PCW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= {N{1'b0}};
                pc_mem_r[i]    <= {PCW{1'b0}};
            end
        end else begin
            pc_r       <= pc_next_s;
            head_r     <= head_next_s;
            tail_r     <= tail_next_s;
            count_r    <= count_next_s;
            instr_r    <= instr_next_s;
            instr_pc_r <= instr_pc_next_s;
            if (push_s) begin
                instr_mem_r[tail_r] <= imem_q;
                pc_mem_r[tail_r]    <= pc_r;
            end
        end
    end

    assign imem_addr   = pc_r[7:2];
    assign occupancy   = count_r;
    assign instr_valid = (count_r != 4'd0);
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle,
// plus directed literal checks of the documented scenarios.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic [3:0]  occupancy;

    logic [31:0] mem [64];

    typedef struct packed {
        logic [31:0] i;
        logic [63:0] p;
    } ent_t;

    ent_t        q[$];
    ent_t        last;
    logic [63:0] mpc;
    int          n_checks = 0;
    int          n_fail = 0;

    fetch_unit #(.N(32), .PCW(64), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    assign imem_q = mem[imem_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model stepped on each rising edge, outputs compared just after.
    initial begin
        bit pop;
        bit full_before;
        last = '0;
        mpc  = 64'd0;
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                mpc  = 64'd0;
                last = '0;
            end else begin
                pop = (q.size() != 0) && instr_ready;
                if (redirect) begin
                    q.delete();
                    mpc = redirect_pc & ~64'h3;
                end else begin
                    full_before = (q.size() == DEPTH);
                    if (pop) void'(q.pop_front());
                    if (!full_before || pop) begin
                        q.push_back({mem[mpc[7:2]], mpc});
                        mpc = mpc + 64'd4;
                    end
                end
            end
            if (q.size() != 0) last = q[0];
            #1;
            check("m_valid", {63'd0, instr_valid}, {63'd0, q.size() != 0});
            check("m_occupancy", {60'd0, occupancy}, 64'(q.size()));
            check("m_imem_addr", {58'd0, imem_addr}, {58'd0, mpc[7:2]});
            check("m_instr", {32'd0, instr}, {32'd0, last.i});
            check("m_instr_pc", instr_pc, last.p);
        end
    end

    task automatic cyc(input logic rd, input logic [63:0] rpc, input logic rdy);
        @(negedge clk);
        redirect    = rd;
        redirect_pc = rpc;
        instr_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        reset       = 1'b1;
        redirect    = 1'b0;
        instr_ready = rdy;
        @(negedge clk);
        check("rst_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_occ", {60'd0, occupancy}, 64'd0);
        check("rst_instr", {32'd0, instr}, 64'd0);
        check("rst_instr_pc", instr_pc, 64'd0);
        check("rst_imem_addr", {58'd0, imem_addr}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA5000000 | (i * 32'h00010101);
        mem[0]  = 32'hf8000000;
        mem[1]  = 32'hf8008001;
        mem[14] = 32'hcb0e01ce;
        mem[15] = 32'hb400004e;

        // Reset release with ready high: one instruction per cycle from word 0.
        do_reset(1'b1);
        check("c1_instr", {32'd0, instr}, 64'hf8000000);
        check("c1_pc", instr_pc, 64'h0);
        check("c1_valid", {63'd0, instr_valid}, 64'd1);
        cyc(1'b0, 64'd0, 1'b1);
        check("c2_instr", {32'd0, instr}, 64'hf8008001);
        check("c2_pc", instr_pc, 64'h4);

        // Stalled consumer fills the queue, then drains in order.
        do_reset(1'b0);
        check("st_occ1", {60'd0, occupancy}, 64'd1);
        cyc(1'b0, 64'd0, 1'b0);
        check("st_occ2", {60'd0, occupancy}, 64'd2);
        for (int k = 0; k < 3; k++) cyc(1'b0, 64'd0, 1'b0);
        check("st_occ_hold", {60'd0, occupancy}, 64'd2);
        check("st_pc8", {58'd0, imem_addr}, 64'd2);
        check("st_instr_hold", {32'd0, instr}, 64'hf8000000);
        cyc(1'b0, 64'd0, 1'b1);
        check("dr_instr1", {32'd0, instr}, 64'hf8008001);
        check("dr_occ_full", {60'd0, occupancy}, 64'd2);
        cyc(1'b0, 64'd0, 1'b1);
        check("dr_pc2", instr_pc, 64'h8);
        check("dr_instr2", {32'd0, instr}, {32'd0, mem[2]});

        // Redirect on a full queue to an unaligned target.
        cyc(1'b1, 64'h3B, 1'b0);
        check("rd_occ0", {60'd0, occupancy}, 64'd0);
        check("rd_valid0", {63'd0, instr_valid}, 64'd0);
        check("rd_pc38", {58'd0, imem_addr}, 64'd14);
        cyc(1'b0, 64'd0, 1'b1);
        check("rd_tgt_pc", instr_pc, 64'h38);
        check("rd_tgt_instr", {32'd0, instr}, 64'hcb0e01ce);

        // Back-to-back redirects, the first coinciding with a pop.
        cyc(1'b1, 64'h10, 1'b1);
        cyc(1'b1, 64'h3C, 1'b1);
        check("bb_occ0", {60'd0, occupancy}, 64'd0);
        cyc(1'b0, 64'd0, 1'b1);
        check("bb_pc", instr_pc, 64'h3C);
        check("bb_instr", {32'd0, instr}, 64'hb400004e);
        cyc(1'b0, 64'd0, 1'b1);
        check("bb_next_pc", instr_pc, 64'h40);

        // Word-address wrap at the top of the 64-word window.
        cyc(1'b1, 64'hF8, 1'b1);
        check("wr_addr62", {58'd0, imem_addr}, 64'd62);
        cyc(1'b0, 64'd0, 1'b1);
        check("wr_pcF8", instr_pc, 64'hF8);
        check("wr_addr63", {58'd0, imem_addr}, 64'd63);
        cyc(1'b0, 64'd0, 1'b1);
        check("wr_pcFC", instr_pc, 64'hFC);
        check("wr_addr0", {58'd0, imem_addr}, 64'd0);
        cyc(1'b0, 64'd0, 1'b1);
        check("wr_pc100", instr_pc, 64'h100);
        check("wr_instr100", {32'd0, instr}, {32'd0, mem[0]});
        cyc(1'b0, 64'd0, 1'b1);
        check("wr_pc104", instr_pc, 64'h104);

        // Full PC wrap modulo 2^64.
        cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        cyc(1'b0, 64'd0, 1'b1);
        check("pw_pc_top", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("pw_addr0", {58'd0, imem_addr}, 64'd0);
        cyc(1'b0, 64'd0, 1'b1);
        check("pw_pc0", instr_pc, 64'h0);

        // Mixed stall/redirect pattern checked by the model alone.
        for (int i = 0; i < 40; i++) begin
            cyc((i == 12) || (i == 13) || (i == 29), 64'(i * 20 + 3),
                (i % 4 != 1) && (i % 7 != 3));
        end

        // Asynchronous reset mid-cycle with a full queue.
        cyc(1'b0, 64'd0, 1'b0);
        cyc(1'b0, 64'd0, 1'b0);
        check("ar_occ2", {60'd0, occupancy}, 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid0", {63'd0, instr_valid}, 64'd0);
        check("ar_occ0", {60'd0, occupancy}, 64'd0);
        check("ar_addr0", {58'd0, imem_addr}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        instr_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter N, default 32, SHALL set the instruction width.
REQ-002 Parameter PCW, default 64, SHALL set the program-counter width.
REQ-003 Parameter DEPTH, default 2, SHALL set the instruction queue depth in entries (range 2..8).
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 imem_addr  out  6  SHALL be the word address to instruction memory, equal to pc[7:2].
REQ-007 imem_q  in  N  SHALL be the combinational read data from instruction memory for imem_addr.
REQ-008 redirect  in  1  SHALL request a PC redirect (taken branch) this cycle.
REQ-009 redirect_pc  in  PCW  SHALL be the redirect target byte address.
REQ-010 instr_valid  out  1  SHALL indicate that instr/instr_pc hold a valid queued instruction.
REQ-011 instr_ready  in  1  SHALL indicate that the consumer accepts the head entry this cycle.
REQ-012 instr  out  N  SHALL be the instruction word at the queue head.
REQ-013 instr_pc  out  PCW  SHALL be the byte address of instr.
REQ-014 occupancy  out  4  SHALL be the number of valid queue entries (0..DEPTH).

Function
REQ-015 The unit SHALL hold a PCW-bit register pc and a FIFO of DEPTH entries, each {instr, instr_pc}.
REQ-016 Pop SHALL occur when instr_valid && instr_ready, removing the head entry at the clock edge.
REQ-017 Push SHALL occur when redirect is 0 and (occupancy < DEPTH or pop occurs), writing {imem_q, pc} to the tail; pc SHALL then advance by 4.
REQ-018 When no push occurs and redirect is 0, pc SHALL hold.
REQ-019 pc SHALL wrap modulo 2^PCW; imem_addr SHALL wrap modulo 64 words, with no error indication.
REQ-020 Full with simultaneous pop SHALL push and pop in the same cycle; occupancy SHALL remain DEPTH.
REQ-021 Empty queue SHALL drive instr_valid 0; instr and instr_pc SHALL then be don't-care to the consumer and SHALL hold their last values.
REQ-022 instr_valid SHALL equal (occupancy != 0) and be registered-state derived, not combinational from instr_ready.
REQ-023 Redirect SHALL take priority over push and pop: on redirect=1 the queue SHALL flush to empty, no push SHALL occur, and pc SHALL load {redirect_pc[PCW-1:2], 2'b00}.
REQ-024 A handshake asserted in the same cycle as redirect SHALL count as consumed by the consumer; the entry SHALL be discarded by the flush.
REQ-025 Redirect latency: the target instruction SHALL appear with instr_valid=1 exactly 2 cycles after the redirect cycle when instr_ready stays 1 (flush cycle, fetch cycle).
REQ-026 Back-to-back redirects SHALL each flush; only the last target SHALL be fetched.
REQ-027 Steady-state throughput with instr_ready=1 SHALL be one instruction per cycle.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; entries SHALL leave in program order.

Reset
REQ-029 While reset=1: pc=0, queue empty, occupancy=0, instr_valid=0, instr=0, instr_pc=0, imem_addr=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries and any pending redirect immediately.
REQ-031 The first push SHALL occur on the first rising edge after reset deasserts, fetching word 0.

Verification
REQ-032 Reset release, instr_ready=1, memory words 0/1 = f8000000/f8008001 -> cycle 1: instr=f8000000, instr_pc=0; cycle 2: instr=f8008001, instr_pc=4.
REQ-033 instr_ready=0 for 5 cycles after reset -> occupancy 1 then 2 and stays 2, pc=8, instr=f8000000 held; then ready=1 -> f8000000, f8008001, then word 2 (pc 8) in consecutive cycles.
REQ-034 Redirect with redirect_pc=0x3B while queue full -> next cycle occupancy=0, instr_valid=0, pc=0x38; following cycle instr_pc=0x38 with word 14 (cb0e01ce).
REQ-035 Redirect and pop in same cycle, then redirect again next cycle to 0x3C -> only instr_pc=0x3C (b400004e) appears; no entry from the first target.
REQ-036 pc run from 0xF8 with ready=1 -> imem_addr 62, 63, 0, 1; instr_pc 0xF8, 0xFC, 0x100, 0x104.
REQ-037 Reset asserted asynchronously mid-cycle with occupancy=2 -> instr_valid and occupancy drop to 0 before the next clock edge.
